// File: rtl/cfg_lut_bank_pkg.sv
// Shared types and constants for the serially configured LUT bank.
// Holds the loader state encoding, default sync header and word widths.
// No logic; imported by cfg_lut_bank and lut_cell.
package cfg_lut_bank_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOAD   = 2'd1,
    SUM    = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [15:0] HDR_DEFAULT = 16'hA55A;
  localparam int          CSUM_W      = 8;
  localparam int          INIT_W      = 16;

endpackage

// File: rtl/lut_cell.sv
// One 4-input LUT: selects bit idx of a 16-bit INIT word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state.
module lut_cell
  import cfg_lut_bank_pkg::*;
(
  input  logic [INIT_W-1:0] init,
  input  logic [3:0]        idx,
  output logic              out
);

  assign out = init[idx];

endmodule

// File: rtl/cfg_lut_bank.sv
// Bank of NLUT runtime-configurable 4-input LUTs loaded from a serial, checksummed frame.
// Latency: lut_out is combinational from the active INIT set; a good frame takes effect the cycle after COMMIT.
// Backpressure: cfg_ready drops for the single COMMIT cycle and while in reset; otherwise every valid bit is taken.
module cfg_lut_bank
  import cfg_lut_bank_pkg::*;
#(
  parameter int                NLUT = 8,
  parameter logic [INIT_W-1:0] HDR  = HDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic [4*NLUT-1:0] lut_in,
  output logic [NLUT-1:0]   lut_out
);

  localparam int SH_W  = NLUT * INIT_W;
  localparam int CNT_W = $clog2(SH_W) + 1;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(SH_W - 1);
  localparam logic [CNT_W-1:0] SUM_LAST  = CNT_W'(CSUM_W - 1);

  state_t              state_q,  state_d;
  logic [INIT_W-1:0]   window_q, window_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [SH_W-1:0]     shadow_q, shadow_d;
  logic [SH_W-1:0]     active_q, active_d;
  logic [CSUM_W-1:0]   sum_q,    sum_d;
  logic                done_q,   done_d;
  logic                err_q,    err_d;
  logic                rdy_q,    rdy_d;

  logic                accept;
  logic [INIT_W-1:0]   win_shift;
  logic [CSUM_W-1:0]   csum_calc;

  // Ready is suppressed during reset and the COMMIT cycle only.
  assign cfg_ready = rdy_q && (state_q != COMMIT);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign accept    = cfg_valid && cfg_ready;
  assign win_shift = {window_q[INIT_W-2:0], cfg_bit};

  // XOR of every byte in the shadow store, compared against the received checksum.
  always_comb begin
    csum_calc = '0;
    for (int i = 0; i < SH_W / CSUM_W; i++) begin
      csum_calc = csum_calc ^ shadow_q[i*CSUM_W +: CSUM_W];
    end
  end

  // Loader next-state: header hunt, payload shift, checksum shift, then commit or flag error.
  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    sum_d    = sum_q;
    done_d   = done_q;
    err_d    = err_q;
    rdy_d    = 1'b1;
    case (state_q)
      HUNT: begin
        if (accept) begin
          window_d = win_shift;
          if (win_shift == HDR) begin
            state_d  = LOAD;
            window_d = '0;
            cnt_d    = '0;
          end
        end
      end
      LOAD: begin
        // Left shift puts the first bit (MSB of word NLUT-1) at the top of the store.
        if (accept) begin
          shadow_d = {shadow_q[SH_W-2:0], cfg_bit};
          if (cnt_q == LOAD_LAST) begin
            state_d = SUM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SUM: begin
        if (accept) begin
          sum_d = {sum_q[CSUM_W-2:0], cfg_bit};
          if (cnt_q == SUM_LAST) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        state_d  = HUNT;
        window_d = '0;
        cnt_d    = '0;
        if (csum_calc == sum_q) begin
          active_d = shadow_q;
          done_d   = 1'b1;
          err_d    = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d  = HUNT;
        window_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // State registers; reset aborts any frame in progress without touching active beyond clearing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      window_q <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      sum_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      sum_q    <= sum_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

  for (genvar k = 0; k < NLUT; k++) begin : g_lut
    lut_cell u_cell (
      .init (active_q[k*INIT_W +: INIT_W]),
      .idx  (lut_in[4*k +: 4]),
      .out  (lut_out[k])
    );
  end

endmodule

// File: tb/tb_cfg_lut_bank.sv
// Randomized self-checking bench for cfg_lut_bank against an array-based INIT model.
module tb_cfg_lut_bank;
  import cfg_lut_bank_pkg::*;

  localparam int NLUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_bit = 1'b0;
  logic              cfg_ready;
  logic              cfg_done;
  logic              cfg_err;
  logic [4*NLUT-1:0] lut_in = '1;
  logic [NLUT-1:0]   lut_out;

  cfg_lut_bank #(.NLUT(NLUT), .HDR(16'hA55A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .lut_in    (lut_in),
    .lut_out   (lut_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] act[NLUT];
  logic [15:0] frm[NLUT];
  logic        exp_done;
  logic        exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NLUT-1:0] model_out(input logic [4*NLUT-1:0] li);
    logic [NLUT-1:0] r;
    logic [3:0]      nib;
    for (int k = 0; k < NLUT; k++) begin
      nib  = li[4*k +: 4];
      r[k] = act[k][nib];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NLUT; k++) act[k] = 16'h0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic check_luts(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lut_in = $urandom;
      #1;
      check_eq(tag, 32'(lut_out), 32'(model_out(lut_in)));
    end
  endtask

  task automatic send_bit(input logic b, input bit gap);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cfg_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_eq("ready_timeout", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'($urandom);
    if (gap) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
  endtask

  // Sends header, frm[NLUT-1..0] and checksum^flip, then updates the model.
  task automatic send_frame(input logic [7:0] flip, input bit gap, input string tag);
    logic [7:0] cs;
    cs = 8'h00;
    for (int k = 0; k < NLUT; k++) cs = cs ^ frm[k][15:8] ^ frm[k][7:0];
    send_bits(32'hA55A, 16, gap);
    for (int k = NLUT - 1; k >= 0; k--) send_bits(32'(frm[k]), 16, gap);
    send_bits(32'(cs ^ flip), 8, gap);
    repeat (3) @(negedge clk);
    if (flip == 8'h00) begin
      act      = frm;
      exp_done = 1'b1;
      exp_err  = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    check_eq({tag, "_done"}, 32'(cfg_done), 32'(exp_done));
    check_eq({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
  endtask

  task automatic rand_frame();
    for (int k = 0; k < NLUT; k++) frm[k] = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [3:0] v;
    model_reset();

    // Reset state, then idle.
    #12;
    check_eq("rst_ready", 32'(cfg_ready), 32'd0);
    check_eq("rst_done", 32'(cfg_done), 32'd0);
    check_eq("rst_err", 32'(cfg_err), 32'd0);
    check_eq("rst_lut", 32'(lut_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("ready_before_edge", 32'(cfg_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("ready_after_edge", 32'(cfg_ready), 32'd1);
    check_eq("idle_lut", 32'(lut_out), 32'd0);
    check_eq("idle_done", 32'(cfg_done), 32'd0);

    // All words 0x8000: only index 15 is set, checksum is zero.
    for (int j = 0; j < NLUT; j++) frm[j] = 16'h8000;
    send_frame(8'h00, 1'b0, "f8000");
    @(negedge clk);
    lut_in = {NLUT{4'hF}};
    #1;
    check_eq("f8000_nibF", 32'(lut_out), 32'hFF);
    lut_in = {NLUT{4'hE}};
    #1;
    check_eq("f8000_nibE", 32'(lut_out), 32'h00);

    // Random good frames, including one with a header pattern embedded as data.
    rand_frame();
    send_frame(8'h00, 1'b0, "rand1");
    check_luts("rand1_lut", 8);
    rand_frame();
    frm[3] = 16'hA55A;
    frm[4] = 16'hA55A;
    send_frame(8'h00, 1'b0, "hdr_in_data");
    check_luts("hdr_in_data_lut", 8);

    // Bad checksum: active retained, error set, done held.
    rand_frame();
    send_frame(8'(1 << $urandom_range(7, 0)), 1'b0, "badcs");
    check_luts("badcs_lut", 8);

    // Good frame clears the error.
    rand_frame();
    send_frame(8'h00, 1'b0, "recover");
    check_luts("recover_lut", 6);

    // Noise before header with valid toggling every other cycle.
    send_bits(32'h5A5, 12, 1'b1);
    rand_frame();
    send_frame(8'h00, 1'b1, "noise_gap");
    check_luts("noise_gap_lut", 6);

    // Reset part-way through LOAD: no partial commit, then a full frame.
    rand_frame();
    send_bits(32'hA55A, 16, 1'b0);
    send_bits(32'($urandom), 32, 1'b0);
    send_bits(32'($urandom), 8, 1'b0);
    #1;
    check_eq("midload_lut_hold", 32'(lut_out), 32'(model_out(lut_in)));
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_ready", 32'(cfg_ready), 32'd0);
    check_eq("midrst_lut", 32'(lut_out), 32'd0);
    check_eq("midrst_done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_luts("post_rst_lut", 4);
    rand_frame();
    send_frame(8'h00, 1'b0, "after_rst");
    check_luts("after_rst_lut", 6);

    // XOR4 function in a random slot; exhaustive over its nibble.
    rand_frame();
    k = $urandom_range(NLUT - 1, 0);
    frm[k] = 16'h6996;
    send_frame(8'h00, 1'b0, "xor4");
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      v = 4'(n);
      lut_in = {NLUT{v}};
      #1;
      check_eq($sformatf("xor4_k%0d_n%0d", k, n), 32'(lut_out[k]), 32'(^v));
    end
    check_luts("xor4_all", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
